// File: rtl/uart_frame_ctrl.sv
// UART frame sequencer: receive RX_LEN bytes into memory, run the processor, stream TX_LEN bytes back.
// Optional trailing checksum byte when UART_FRAME_CTRL_CHECKSUM_EN is defined.
module uart_frame_ctrl #(
    parameter int ADDR_W = 16,
    parameter int RX_LEN = 65536,
    parameter int TX_LEN = 16384
) (
    input  logic              clk_,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              rdy_clr,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    output logic              proc_start,
    input  logic              proc_done,
    output logic [1:0]        phase,
    output logic              frame_done
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] RX_END = CW'(RX_LEN);
    localparam logic [CW-1:0] TX_END = CW'(TX_LEN);
    localparam logic [1:0] PH_RX   = 2'd0;
    localparam logic [1:0] PH_PROC = 2'd1;
    localparam logic [1:0] PH_TX   = 2'd2;

    typedef enum logic [3:0] {
        S_RX_WAIT,
        S_RX_CLR,
        S_PROC_START,
        S_PROC_WAIT,
        S_TX_ADDR,
        S_TX_MEM,
        S_TX_LOAD,
        S_TX_REQ,
        S_TX_DONEWAIT,
        S_TX_CSUM
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_rdy_clr;
    logic [7:0]        r_tx_data;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic              r_mem_we;
    logic              r_proc_start;
    logic [1:0]        r_phase;
    logic              r_frame_done;
`ifdef UART_FRAME_CTRL_CHECKSUM_EN
    logic [7:0]        r_sum;
    logic              r_csum_sent;
`endif

    logic [CW-1:0]     w_cnt_inc;
    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk_) begin
        if (rst) begin
            r_state      <= S_RX_WAIT;
            r_cnt        <= '0;
            r_rdy_clr    <= 1'b0;
            r_tx_data    <= '0;
            r_wr_en      <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 1'b0;
            r_proc_start <= 1'b0;
            r_phase      <= PH_RX;
            r_frame_done <= 1'b0;
`ifdef UART_FRAME_CTRL_CHECKSUM_EN
            r_sum        <= '0;
            r_csum_sent  <= 1'b0;
`endif
        end else begin
            r_mem_we     <= 1'b0;
            r_proc_start <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_RX_WAIT: begin
                    if (rx_rdy) begin
                        r_mem_addr  <= r_cnt[ADDR_W-1:0];
                        r_mem_wdata <= rx_data;
                        r_mem_we    <= 1'b1;
                        r_rdy_clr   <= 1'b1;
                        r_state     <= S_RX_CLR;
                    end
                end
                // Counting only on rx_rdy release guarantees each byte is written once.
                S_RX_CLR: begin
                    if (!rx_rdy) begin
                        r_rdy_clr <= 1'b0;
                        if (w_cnt_inc == RX_END) begin
                            r_cnt   <= '0;
                            r_state <= S_PROC_START;
                        end else begin
                            r_cnt   <= w_cnt_inc;
                            r_state <= S_RX_WAIT;
                        end
                    end
                end
                S_PROC_START: begin
                    r_proc_start <= 1'b1;
                    r_phase      <= PH_PROC;
                    r_state      <= S_PROC_WAIT;
                end
                S_PROC_WAIT: begin
                    if (proc_done) begin
`ifdef UART_FRAME_CTRL_CHECKSUM_EN
                        r_sum       <= '0;
                        r_csum_sent <= 1'b0;
`endif
                        r_state <= S_TX_ADDR;
                    end
                end
                S_TX_ADDR: begin
                    r_mem_addr <= r_cnt[ADDR_W-1:0];
                    r_phase    <= PH_TX;
                    r_state    <= S_TX_MEM;
                end
                S_TX_MEM: r_state <= S_TX_LOAD;
                S_TX_LOAD: begin
                    r_tx_data <= mem_rdata;
`ifdef UART_FRAME_CTRL_CHECKSUM_EN
                    r_sum     <= r_sum + mem_rdata;
`endif
                    r_state   <= S_TX_REQ;
                end
                // Request is raised only once the transmitter is idle, dropped once it goes busy.
                S_TX_REQ: begin
                    if (!r_wr_en) begin
                        if (!tx_busy) r_wr_en <= 1'b1;
                    end else if (tx_busy) begin
                        r_wr_en <= 1'b0;
                        r_state <= S_TX_DONEWAIT;
                    end
                end
                S_TX_DONEWAIT: begin
                    if (!tx_busy) begin
`ifdef UART_FRAME_CTRL_CHECKSUM_EN
                        if (r_csum_sent) begin
                            r_csum_sent  <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_phase      <= PH_RX;
                            r_state      <= S_RX_WAIT;
                        end else if (w_cnt_inc == TX_END) begin
                            r_cnt   <= '0;
                            r_state <= S_TX_CSUM;
                        end
`else
                        if (w_cnt_inc == TX_END) begin
                            r_cnt        <= '0;
                            r_frame_done <= 1'b1;
                            r_phase      <= PH_RX;
                            r_state      <= S_RX_WAIT;
                        end
`endif
                        else begin
                            r_cnt   <= w_cnt_inc;
                            r_state <= S_TX_ADDR;
                        end
                    end
                end
`ifdef UART_FRAME_CTRL_CHECKSUM_EN
                S_TX_CSUM: begin
                    r_tx_data   <= r_sum;
                    r_csum_sent <= 1'b1;
                    r_state     <= S_TX_REQ;
                end
`endif
                default: r_state <= S_RX_WAIT;
            endcase
        end
    end

    assign rdy_clr    = r_rdy_clr;
    assign tx_data    = r_tx_data;
    assign wr_en      = r_wr_en;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_we     = r_mem_we;
    assign proc_start = r_proc_start;
    assign phase      = r_phase;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl with RX_LEN=4, TX_LEN=2, ADDR_W=4.
module tb_uart_frame_ctrl;

    localparam int AW  = 4;
    localparam int RXL = 4;
    localparam int TXL = 2;
`ifdef UART_FRAME_CTRL_CHECKSUM_EN
    localparam int NTX = TXL + 1;
`else
    localparam int NTX = TXL;
`endif

    logic          clk_ = 1'b0;
    logic          rst;
    logic          rx_rdy;
    logic [7:0]    rx_data;
    logic          rdy_clr;
    logic          tx_busy = 1'b0;
    logic [7:0]    tx_data;
    logic          wr_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic [7:0]    mem_rdata;
    logic          proc_start;
    logic          proc_done;
    logic [1:0]    phase;
    logic          frame_done;

    always #5 clk_ = ~clk_;

    uart_frame_ctrl #(.ADDR_W(AW), .RX_LEN(RXL), .TX_LEN(TXL)) dut (
        .clk_(clk_), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .rdy_clr(rdy_clr),
        .tx_busy(tx_busy), .tx_data(tx_data), .wr_en(wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .proc_start(proc_start), .proc_done(proc_done), .phase(phase), .frame_done(frame_done)
    );

    // Memory model with synchronous read, write logging and event counters.
    logic [7:0] mem [0:15];
    logic       tb_load = 1'b0;
    logic [3:0] wl_addr [0:63];
    logic [7:0] wl_data [0:63];
    logic [7:0] tx_log  [0:63];
    int n_we = 0, n_start = 0, n_fd = 0, n_ovl = 0, n_hand = 0, n_tx = 0;
    int run = 0, last_run = 0;
    logic prev_wr = 1'b0;

    always @(posedge clk_) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wl_addr[n_we[5:0]] <= mem_addr;
            wl_data[n_we[5:0]] <= mem_wdata;
            n_we <= n_we + 1;
        end
        if (tb_load) begin
            mem[0] <= 8'hA5;
            mem[1] <= 8'h5A;
        end
        mem_rdata <= mem[mem_addr];
        if (proc_start) n_start <= n_start + 1;
        if (frame_done) n_fd <= n_fd + 1;
        if (wr_en && mem_we) n_ovl <= n_ovl + 1;
        if (wr_en && tx_busy) n_hand <= n_hand + 1;
        prev_wr <= wr_en;
        if (wr_en) begin
            if (!prev_wr) begin
                tx_log[n_tx[5:0]] <= tx_data;
                n_tx <= n_tx + 1;
            end
            run <= run + 1;
        end else if (prev_wr) begin
            last_run <= run;
            run <= 0;
        end
    end

    // Transmitter model: busy rises busy_delay edges after wr_en is seen, stays 4 cycles.
    int busy_delay = 3;
    int dcnt = 0, bcnt = 0;
    logic pend = 1'b0;
    always @(posedge clk_) begin
        if (tx_busy) begin
            if (bcnt == 0) tx_busy <= 1'b0;
            else bcnt <= bcnt - 1;
        end else if (pend) begin
            if (dcnt <= 1) begin
                tx_busy <= 1'b1;
                bcnt    <= 3;
                pend    <= 1'b0;
            end else dcnt <= dcnt - 1;
        end else if (wr_en) begin
            pend <= 1'b1;
            dcnt <= busy_delay;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        int nw0;
        nw0 = n_we;
        @(negedge clk_);
        rx_data = b;
        rx_rdy  = 1'b1;
        k = 0;
        while (rdy_clr !== 1'b1 && k < 20) begin @(negedge clk_); k++; end
        chk("rdy_clr_rise", 32'(rdy_clr), 32'(1));
        repeat (2) @(negedge clk_);
        chk("single_write", n_we - nw0, 1);
        rx_rdy = 1'b0;
        k = 0;
        while (rdy_clr !== 1'b0 && k < 20) begin @(negedge clk_); k++; end
        chk("rdy_clr_fall", 32'(rdy_clr), 32'(0));
    endtask

    task automatic wait_fd(input int fd0, input int max);
        int k;
        k = 0;
        while (n_fd == fd0 && k < max) begin @(negedge clk_); k++; end
        repeat (5) @(negedge clk_);
        chk("frame_done_once", n_fd - fd0, 1);
    endtask

    task automatic check_tx(input string tag, input int nt0, input int nh0, input int exp_run);
        logic [5:0] i0;
        i0 = 6'(nt0);
        chk({tag, "_count"}, n_tx - nt0, NTX);
        chk({tag, "_byte0"}, 32'(tx_log[i0]), 32'hA5);
        chk({tag, "_byte1"}, 32'(tx_log[i0 + 6'd1]), 32'h5A);
`ifdef UART_FRAME_CTRL_CHECKSUM_EN
        chk({tag, "_csum"}, 32'(tx_log[i0 + 6'd2]), 32'hFF);
`endif
        chk({tag, "_handshake"}, n_hand - nh0, NTX);
        chk({tag, "_wr_en_run"}, last_run, exp_run);
        chk({tag, "_phase_rx"}, 32'(phase), 32'(0));
    endtask

    task automatic check_writes(input int nw0, input int n, input logic [3:0] ea [0:5],
                                input logic [7:0] ed [0:5]);
        logic [5:0] idx;
        for (int i = 0; i < n; i++) begin
            idx = 6'(nw0 + i);
            chk("wr_addr", 32'(wl_addr[idx]), 32'(ea[i]));
            chk("wr_data", 32'(wl_data[idx]), 32'(ed[i]));
        end
    endtask

    initial begin
        int nw0, ns0, nt0, nh0, fd0;
        logic [3:0] ea [0:5];
        logic [7:0] ed [0:5];

        // Reset held with rx_rdy high must not capture anything.
        rst = 1'b1; rx_rdy = 1'b1; rx_data = 8'h99; proc_done = 1'b0;
        repeat (3) begin
            @(negedge clk_);
            chk("reset_outputs", 32'({rdy_clr, wr_en, mem_we, proc_start, frame_done, phase,
                                      mem_addr, mem_wdata, tx_data}), 32'(0));
        end
        rx_rdy = 1'b0;
        @(negedge clk_);
        rst = 1'b0;
        chk("reset_no_we", n_we, 0);

        // Receive one frame.
        nw0 = n_we; ns0 = n_start;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        chk("no_start_early", n_start - ns0, 0);
        send_byte(8'h44);
        repeat (3) @(negedge clk_);
        chk("proc_start_once", n_start - ns0, 1);
        chk("phase_proc", 32'(phase), 32'(1));
        chk("rx_we_count", n_we - nw0, RXL);
        ea = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd0};
        ed = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
        check_writes(nw0, 4, ea, ed);

        // Transmit with a 3-cycle busy delay: wr_en seen high for delay+2 edges.
        @(negedge clk_); tb_load = 1'b1;
        @(negedge clk_); tb_load = 1'b0;
        nt0 = n_tx; nh0 = n_hand; fd0 = n_fd; nw0 = n_we;
        busy_delay = 3;
        proc_done = 1'b1;
        wait_fd(fd0, 300);
        proc_done = 1'b0;
        check_tx("tx", nt0, nh0, 5);
        chk("no_we_in_tx", n_we - nw0, 0);

        // Slow transmitter; proc_done already high long before PROC_WAIT.
        busy_delay = 19;
        proc_done = 1'b1;
        ns0 = n_start;
        send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h01);
        chk("proc_done_ignored_phase", 32'(phase), 32'(0));
        chk("proc_done_ignored_start", n_start - ns0, 0);
        nt0 = n_tx; nh0 = n_hand; fd0 = n_fd;
        send_byte(8'h02);
        wait_fd(fd0, 800);
        proc_done = 1'b0;
        check_tx("slow", nt0, nh0, 21);

        // Reset after two bytes: the next frame restarts at address 0.
        busy_delay = 3;
        nw0 = n_we; ns0 = n_start;
        send_byte(8'h61); send_byte(8'h62);
        @(negedge clk_); rst = 1'b1;
        @(negedge clk_); rst = 1'b0;
        chk("mid_reset_phase", 32'(phase), 32'(0));
        send_byte(8'h71); send_byte(8'h72); send_byte(8'h73);
        chk("mid_no_start_early", n_start - ns0, 0);
        send_byte(8'h74);
        repeat (3) @(negedge clk_);
        chk("mid_proc_start_once", n_start - ns0, 1);
        chk("mid_we_count", n_we - nw0, 6);
        ea = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd2, 4'd3};
        ed = '{8'h61, 8'h62, 8'h71, 8'h72, 8'h73, 8'h74};
        check_writes(nw0, 6, ea, ed);

        chk("we_wr_en_overlap", n_ovl, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
- Sequences the UART link around the image processor.
- Receives a fixed-length frame of RX_LEN bytes from the UART receiver into image memory, then pulses the processor start and waits for its done.
- Then streams TX_LEN result bytes from memory to the UART transmitter and returns to receive the next frame.
- Sits between uart_module, the image BRAM and the processor core; it is the only master of the UART handshakes.

Parameters:
- ADDR_W, 16, memory address width; the frame counter is ADDR_W+1 bits wide.
- RX_LEN, 65536, bytes per received frame (256x256 image); legal range 1..2^ADDR_W.
- TX_LEN, 16384, bytes per transmitted result (128x128 sampled image); legal range 1..2^ADDR_W.

Ports:
- clk_  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_rdy  in  1  receiver byte-ready flag (level; stays high until cleared)
- rx_data  in  8  received byte
- rdy_clr  out  1  clears receiver ready flag
- tx_busy  in  1  transmitter busy (tx_state)
- tx_data  out  8  byte to transmitter
- wr_en  out  1  transmit request
- mem_addr  out  ADDR_W  memory address (registered)
- mem_wdata  out  8  write data
- mem_we  out  1  write strobe
- mem_rdata  in  8  read data; synchronous read, valid one edge after address sampled
- proc_start  out  1  one-cycle start pulse to processor
- proc_done  in  1  processor done (level)
- phase  out  2  0=RX, 1=PROC, 2=TX
- frame_done  out  1  one-cycle pulse after the last TX byte completes

Behaviour:
- Reset (synchronous, rst=1 at clk_ edge): all outputs go to 0 and state goes to RX_WAIT. Counter and address go to 0. Reset mid-operation abandons the frame; the next frame starts at address 0.
- RX_WAIT: on rx_rdy=1, register mem_addr=cnt, mem_wdata=rx_data, mem_we=1 (exactly one cycle) and rdy_clr=1. Go to RX_CLR.
- RX_CLR: hold rdy_clr=1 until rx_rdy=0, then drop rdy_clr and increment cnt.
  - If cnt reached RX_LEN: clear cnt, go to PROC_START.
  - Otherwise return to RX_WAIT.
  - A byte is therefore never written twice.
- PROC_START: proc_start=1 for exactly one cycle, phase=1, then PROC_WAIT.
- PROC_WAIT: proc_done is sampled only in this state. proc_done=1 (even if already high on entry) goes to TX_ADDR. proc_done outside PROC_WAIT is ignored.
- TX_ADDR: mem_addr=cnt, phase=2, then TX_MEM (one wait cycle).
- TX_LOAD: capture tx_data=mem_rdata. mem_rdata is sampled two edges after the edge that updated mem_addr.
- TX_REQ: wr_en=1, held until tx_busy=1 is sampled, then wr_en=0, go to TX_DONEWAIT. If tx_busy is already 1 on entry, wait for 0 before asserting wr_en.
- TX_DONEWAIT: wait for tx_busy=0, then increment cnt.
  - If cnt reached TX_LEN: pulse frame_done for 1 cycle, clear cnt, go to RX_WAIT.
  - Otherwise go to TX_ADDR.
- rx_rdy during PROC/TX phases is ignored and not cleared.
- tx_data is stable from TX_LOAD until the next TX_LOAD.
- Counter compare uses ADDR_W+1 bits, so RX_LEN=2^ADDR_W is legal; the address is cnt[ADDR_W-1:0].
- mem_we is never asserted outside RX_WAIT→RX_CLR.
- wr_en and mem_we are never high together.

Optional Feature:
- UART_FRAME_CTRL_CHECKSUM_EN defined: keep an 8-bit running sum (mod 256) of every transmitted byte, cleared at TX entry. After byte TX_LEN, transmit one extra byte = sum, using the same TX_REQ/TX_DONEWAIT handshake. frame_done pulses after the checksum byte completes.
- Undefined: no checksum logic; exactly TX_LEN bytes are sent.

Test Plan (RX_LEN=4, TX_LEN=2, ADDR_W=4):
- Reset: hold rst=1 for 3 cycles while rx_rdy=1 → all outputs 0, no mem_we, no rdy_clr, phase=0.
- RX: send 0x11,0x22,0x33,0x44 with rx_rdy high until rdy_clr → mem writes (0,0x11),(1,0x22),(2,0x33),(3,0x44), one mem_we each. proc_start pulses once after the 4th byte; phase=1.
- TX: proc_done=1, memory holds addr0=0xA5, addr1=0x5A; model tx_busy high 3 cycles after wr_en → tx_data 0xA5 then 0x5A. wr_en drops the cycle after tx_busy is seen. frame_done pulses once, phase returns to 0.
- Slow transmitter: tx_busy delayed 20 cycles after wr_en → wr_en stays high all 20 cycles, then exactly one byte is sent.
- Reset mid-RX after 2 bytes, then send 4 new bytes → writes start at addr 0; proc_start fires after the 4th new byte only.
- With UART_FRAME_CTRL_CHECKSUM_EN: same TX case → third byte 0xFF (0xA5+0x5A), frame_done after it. Without the macro → only 2 bytes are sent.
